mc_ctrl_fsm: RTL and testbench

Multi-cycle MIPS control sequencer that replaces single-cycle decode when the datapath shares one memory port and one ALU across cycles. Moore FSM sequences fetch, decode, execute, memory and writeback. It drives PC/IR/register-file/ALU mux controls and a req/ready memory handshake. Covers R-type (incl. jr), lw, sw, beq, j, jal.

---
 rtl/mc_ctrl_fsm_pkg.sv | 165 ++++++++++++++++
 rtl/mc_ctrl_fsm_if.sv | 28 ++
 rtl/mc_ctrl_fsm_wait_timer.sv | 42 ++++
 rtl/mc_ctrl_fsm.sv | 154 +++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_fsm_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multi-cycle MIPS control sequencer:
//   - state_e : sequencer state encoding
//   - OP_* / FN_JR : opcode and funct values recognised in DECODE
//   - PCSRC_* / ALUB_* / ALUOP_* : datapath mux and ALU encodings
//   - ctrl_t : bundle of per-state control outputs
//   - ctrl_for_state() : Moore output table, one entry per state
//   - op_known() : true for every opcode the sequencer implements
// Optional feature macro: MC_ILLEGAL_TRAP_EN (adds the TRAP state behaviour).
// ---------------------------------------------------------------------------
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_RWB,
    S_MEMADDR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_BRANCH,
    S_JUMP,
    S_JAL,
    S_JR,
    S_ERR,
    S_TRAP
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  localparam logic [1:0] ALUB_REGB    = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // fetch_stb marks the FETCH strobes (ir_wr, pc_wr) that may only fire in
  // the cycle memory completes; done_on_ready does the same for the
  // instr_done pulse of a store.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       fetch_stb;
    logic       pc_wr;
    logic       pc_wr_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       ext_op;
    logic       reg_dst;
    logic       reg_wr;
    logic       mem_to_reg;
    logic       link;
    logic       instr_done;
    logic       done_on_ready;
    logic       mem_err;
  } ctrl_t;

  // Moore output table: every control not set for a state stays 0.
  function automatic ctrl_t ctrl_for_state(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.fetch_stb = 1'b1;
        c.alu_src_b = ALUB_FOUR;
        c.alu_op    = ALUOP_ADD;
      end
      S_DECODE: begin
        c.alu_src_b = ALUB_IMM_SH2;
        c.ext_op    = 1'b1;
        c.alu_op    = ALUOP_ADD;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = ALUB_REGB;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        c.reg_dst    = 1'b1;
        c.reg_wr     = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = ALUB_IMM;
        c.ext_op    = 1'b1;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_wr     = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMWR: begin
        c.mem_req       = 1'b1;
        c.mem_we        = 1'b1;
        c.iord          = 1'b1;
        c.done_on_ready = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = ALUB_REGB;
        c.alu_op     = ALUOP_SUB;
        c.pc_wr_cond = 1'b1;
        c.pc_src     = PCSRC_ALUOUT;
        c.instr_done = 1'b1;
      end
      S_JUMP: begin
        c.pc_wr      = 1'b1;
        c.pc_src     = PCSRC_JUMP;
        c.instr_done = 1'b1;
      end
      S_JAL: begin
        c.pc_wr      = 1'b1;
        c.pc_src     = PCSRC_JUMP;
        c.reg_wr     = 1'b1;
        c.link       = 1'b1;
        c.instr_done = 1'b1;
      end
      S_JR: begin
        c.pc_wr      = 1'b1;
        c.pc_src     = PCSRC_RS;
        c.instr_done = 1'b1;
      end
      S_ERR: begin
        c.mem_err = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

  function automatic logic op_known(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J)  || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm_if
// Shared-memory request/ready handshake between the control sequencer and
// the memory port.
//   mem_req   : access request (sequencer -> memory)
//   mem_we    : write strobe, meaningful only with mem_req
//   mem_ready : memory completes the access this cycle (memory -> sequencer)
// Modports: master = sequencer side, slave = memory side.
// ---------------------------------------------------------------------------
interface mc_ctrl_fsm_if;

  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    output mem_ready
  );

endinterface

// File: rtl/mc_ctrl_fsm_wait_timer.sv
// ---------------------------------------------------------------------------
// mc_wait_timer
// Counts memory wait cycles and flags a timeout.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_active   : sequencer is in a memory state (FETCH, MEMRD, MEMWR)
//   i_ready    : memory handshake ready
//   o_timeout  : limit reached while memory is still not ready
// Parameter MEM_TIMEOUT: wait-cycle limit, 0 disables the timeout.
// ---------------------------------------------------------------------------
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_active,
  input  logic i_ready,
  output logic o_timeout
);

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] r_count;

  // A completed access always leaves the memory state, so clearing on
  // ready (or outside memory states) guarantees the count starts at zero
  // on every entry to FETCH, MEMRD and MEMWR, even back-to-back ones.
  // The count saturates so a disabled timeout never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (!i_active || i_ready) begin
      r_count <= '0;
    end else if (r_count != {CW{1'b1}}) begin
      r_count <= r_count + CW'(1);
    end
  end

  // Ready arriving in the limit cycle wins over the timeout.
  assign o_timeout = (MEM_TIMEOUT != 0) && i_active && !i_ready &&
                     (r_count == CW'(MEM_TIMEOUT));

endmodule

// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm
// Multi-cycle MIPS control sequencer (R-type incl. jr, lw, sw, beq, j, jal)
// for a datapath sharing one memory port and one ALU.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   mem (master)    : mem_req / mem_we / mem_ready handshake
//   i_op, i_funct   : IR[31:26], IR[5:0]
//   o_iord, o_ir_wr, o_pc_wr, o_pc_wr_cond, o_pc_src : PC/IR/address control
//   o_alu_src_a, o_alu_src_b, o_alu_op, o_ext_op     : ALU control
//   o_reg_dst, o_reg_wr, o_mem_to_reg, o_link        : register file control
//   o_instr_done    : pulse in the last state of each instruction
//   o_mem_err       : sticky memory timeout flag
//   o_illegal_op    : sticky illegal-opcode flag
// Parameter MEM_TIMEOUT (default 16, 0 disables).
// Optional macro MC_ILLEGAL_TRAP_EN: unknown opcodes trap instead of
// executing as a NOP.
// ---------------------------------------------------------------------------
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mc_ctrl_fsm_if.master        mem,
  input  logic [5:0]           i_op,
  input  logic [5:0]           i_funct,
  output logic                 o_iord,
  output logic                 o_ir_wr,
  output logic                 o_pc_wr,
  output logic                 o_pc_wr_cond,
  output logic [1:0]           o_pc_src,
  output logic                 o_alu_src_a,
  output logic [1:0]           o_alu_src_b,
  output logic [1:0]           o_alu_op,
  output logic                 o_ext_op,
  output logic                 o_reg_dst,
  output logic                 o_reg_wr,
  output logic                 o_mem_to_reg,
  output logic                 o_link,
  output logic                 o_instr_done,
  output logic                 o_mem_err,
  output logic                 o_illegal_op
);

  state_e r_state;
  state_e w_next_state;
  ctrl_t  r_ctrl;
  logic   w_mem_state;
  logic   w_timeout;
  logic   w_nop_done;

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                       (r_state == S_MEMWR);

  mc_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_active (w_mem_state),
    .i_ready  (mem.mem_ready),
    .o_timeout(w_timeout)
  );

  // Next-state selection. Memory states hold until ready or timeout;
  // DECODE dispatches on the freshly loaded IR; ERR and TRAP are terminal.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    w_next_state = S_FETCH;
      S_FETCH: begin
        if (mem.mem_ready)  w_next_state = S_DECODE;
        else if (w_timeout) w_next_state = S_ERR;
      end
      S_DECODE: begin
        case (i_op)
          OP_RTYPE:     w_next_state = (i_funct == FN_JR) ? S_JR : S_EXEC_R;
          OP_LW, OP_SW: w_next_state = S_MEMADDR;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_J:         w_next_state = S_JUMP;
          OP_JAL:       w_next_state = S_JAL;
`ifdef MC_ILLEGAL_TRAP_EN
          default:      w_next_state = S_TRAP;
`else
          default:      w_next_state = S_FETCH;
`endif
        endcase
      end
      S_EXEC_R:  w_next_state = S_RWB;
      S_RWB:     w_next_state = S_FETCH;
      S_MEMADDR: w_next_state = (i_op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem.mem_ready)  w_next_state = S_MEMWB;
        else if (w_timeout) w_next_state = S_ERR;
      end
      S_MEMWB:   w_next_state = S_FETCH;
      S_MEMWR: begin
        if (mem.mem_ready)  w_next_state = S_FETCH;
        else if (w_timeout) w_next_state = S_ERR;
      end
      S_BRANCH, S_JUMP, S_JAL, S_JR: w_next_state = S_FETCH;
      S_ERR:     w_next_state = S_ERR;
      S_TRAP:    w_next_state = S_TRAP;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // State register with registered Moore outputs: the controls for the
  // state being entered are loaded alongside it, so each output matches
  // the state occupied in the same cycle. Reset clears everything at once,
  // dropping any outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_next_state;
      r_ctrl  <= ctrl_for_state(w_next_state);
    end
  end

  // The only input-qualified outputs: strobes that by definition fire in
  // the cycle memory completes, plus the NOP completion in DECODE, which
  // depends on an opcode that is only valid from DECODE onward.
`ifdef MC_ILLEGAL_TRAP_EN
  assign w_nop_done   = 1'b0;
  assign o_illegal_op = (r_state == S_TRAP);
`else
  assign w_nop_done   = (r_state == S_DECODE) && !op_known(i_op);
  assign o_illegal_op = 1'b0;
`endif

  assign mem.mem_req  = r_ctrl.mem_req;
  assign mem.mem_we   = r_ctrl.mem_we;
  assign o_iord       = r_ctrl.iord;
  assign o_ir_wr      = r_ctrl.fetch_stb & mem.mem_ready;
  assign o_pc_wr      = r_ctrl.pc_wr | (r_ctrl.fetch_stb & mem.mem_ready);
  assign o_pc_wr_cond = r_ctrl.pc_wr_cond;
  assign o_pc_src     = r_ctrl.pc_src;
  assign o_alu_src_a  = r_ctrl.alu_src_a;
  assign o_alu_src_b  = r_ctrl.alu_src_b;
  assign o_alu_op     = r_ctrl.alu_op;
  assign o_ext_op     = r_ctrl.ext_op;
  assign o_reg_dst    = r_ctrl.reg_dst;
  assign o_reg_wr     = r_ctrl.reg_wr;
  assign o_mem_to_reg = r_ctrl.mem_to_reg;
  assign o_link       = r_ctrl.link;
  assign o_instr_done = r_ctrl.instr_done |
                        (r_ctrl.done_on_ready & mem.mem_ready) | w_nop_done;
  assign o_mem_err    = r_ctrl.mem_err;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl_fsm
// Directed bench for mc_ctrl_fsm (MEM_TIMEOUT = 4). Each cycle compares the
// full control word against a hand-derived per-state constant.
// Control word layout (bit 20 down to 0):
//   mem_req, mem_we, iord, ir_wr, pc_wr, pc_wr_cond, pc_src[1:0],
//   alu_src_a, alu_src_b[1:0], alu_op[1:0], ext_op, reg_dst, reg_wr,
//   mem_to_reg, link, instr_done, mem_err, illegal_op
// Honours MC_ILLEGAL_TRAP_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

  localparam logic [20:0] E_ZERO      = 21'h000000;
  localparam logic [20:0] E_FETCH_W   = 21'h100400;
  localparam logic [20:0] E_FETCH_R   = 21'h130400;
  localparam logic [20:0] E_DECODE    = 21'h000C80;
  localparam logic [20:0] E_DECODE_NP = 21'h000C84;
  localparam logic [20:0] E_EXEC_R    = 21'h001200;
  localparam logic [20:0] E_RWB       = 21'h000064;
  localparam logic [20:0] E_MEMADDR   = 21'h001880;
  localparam logic [20:0] E_MEMRD     = 21'h140000;
  localparam logic [20:0] E_MEMWB     = 21'h000034;
  localparam logic [20:0] E_MEMWR_W   = 21'h1C0000;
  localparam logic [20:0] E_MEMWR_R   = 21'h1C0004;
  localparam logic [20:0] E_BRANCH    = 21'h00B104;
  localparam logic [20:0] E_JUMP      = 21'h014004;
  localparam logic [20:0] E_JAL       = 21'h01402C;
  localparam logic [20:0] E_JR        = 21'h016004;
  localparam logic [20:0] E_ERR       = 21'h000002;
  localparam logic [20:0] E_TRAP      = 21'h000001;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       iord, irWr, pcWr, pcWrCond, aluSrcA, extOp, regDst, regWr;
  logic       memToReg, link, instrDone, memErr, illegalOp;
  logic [1:0] pcSrc, aluSrcB, aluOp;
  logic [5:0] curOp;
  logic [5:0] curFunct;
  int         errorCount;
  int         checkCount;

  mc_ctrl_fsm_if memIf ();

  mc_ctrl_fsm #(
    .MEM_TIMEOUT(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem         (memIf),
    .i_op        (op),
    .i_funct     (funct),
    .o_iord      (iord),
    .o_ir_wr     (irWr),
    .o_pc_wr     (pcWr),
    .o_pc_wr_cond(pcWrCond),
    .o_pc_src    (pcSrc),
    .o_alu_src_a (aluSrcA),
    .o_alu_src_b (aluSrcB),
    .o_alu_op    (aluOp),
    .o_ext_op    (extOp),
    .o_reg_dst   (regDst),
    .o_reg_wr    (regWr),
    .o_mem_to_reg(memToReg),
    .o_link      (link),
    .o_instr_done(instrDone),
    .o_mem_err   (memErr),
    .o_illegal_op(illegalOp)
  );

  logic [20:0] ctlWord;
  assign ctlWord = {memIf.mem_req, memIf.mem_we, iord, irWr, pcWr, pcWrCond,
                    pcSrc, aluSrcA, aluSrcB, aluOp, extOp, regDst, regWr,
                    memToReg, link, instrDone, memErr, illegalOp};

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives the instruction fields and memory ready for the current cycle.
  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f,
                               input logic ready);
    op              = o;
    funct           = f;
    memIf.mem_ready = ready;
  endtask

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [20:0] observed,
                             input logic [20:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Applies inputs mid-cycle, checks the settled outputs, then advances to
  // just after the next rising edge.
  task automatic runCycle(input string tag, input logic ready,
                          input logic [20:0] expected);
    applyStimulus(curOp, curFunct, ready);
    #1;
    checkOutput(tag, ctlWord, expected);
    @(posedge clk);
    #2;
  endtask

  task automatic setInstr(input logic [5:0] o, input logic [5:0] f);
    curOp    = o;
    curFunct = f;
  endtask

  // Asserts reset off-edge, checks outputs clear immediately, releases.
  task automatic pulseReset(input string tag);
    rst_n = 1'b0;
    #1;
    checkOutput(tag, ctlWord, E_ZERO);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    errorCount = 0;
    checkCount = 0;
    rst_n      = 1'b0;
    setInstr(6'b000000, 6'b100000);
    applyStimulus(curOp, curFunct, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset", ctlWord, E_ZERO);
    rst_n = 1'b1;

    $display("[TB] R-type add");
    runCycle("r_idle",   1'b1, E_ZERO);
    runCycle("r_fetch",  1'b1, E_FETCH_R);
    runCycle("r_decode", 1'b1, E_DECODE);
    runCycle("r_exec",   1'b1, E_EXEC_R);
    runCycle("r_rwb",    1'b1, E_RWB);

    $display("[TB] lw with two wait states");
    setInstr(6'b100011, 6'b000000);
    runCycle("lw_fetch",   1'b1, E_FETCH_R);
    runCycle("lw_decode",  1'b1, E_DECODE);
    runCycle("lw_addr",    1'b1, E_MEMADDR);
    runCycle("lw_rd_w0",   1'b0, E_MEMRD);
    runCycle("lw_rd_w1",   1'b0, E_MEMRD);
    runCycle("lw_rd_rdy",  1'b1, E_MEMRD);
    runCycle("lw_wb",      1'b1, E_MEMWB);

    $display("[TB] sw, beq, j, jal, jr");
    setInstr(6'b101011, 6'b000000);
    runCycle("sw_fetch",  1'b1, E_FETCH_R);
    runCycle("sw_decode", 1'b1, E_DECODE);
    runCycle("sw_addr",   1'b1, E_MEMADDR);
    runCycle("sw_wr_w0",  1'b0, E_MEMWR_W);
    runCycle("sw_wr_rdy", 1'b1, E_MEMWR_R);
    setInstr(6'b000100, 6'b000000);
    runCycle("beq_fetch",  1'b1, E_FETCH_R);
    runCycle("beq_decode", 1'b1, E_DECODE);
    runCycle("beq_branch", 1'b1, E_BRANCH);
    setInstr(6'b000010, 6'b000000);
    runCycle("j_fetch",  1'b1, E_FETCH_R);
    runCycle("j_decode", 1'b1, E_DECODE);
    runCycle("j_jump",   1'b1, E_JUMP);
    setInstr(6'b000011, 6'b000000);
    runCycle("jal_fetch",  1'b1, E_FETCH_R);
    runCycle("jal_decode", 1'b1, E_DECODE);
    runCycle("jal_jal",    1'b1, E_JAL);
    setInstr(6'b000000, 6'b001000);
    runCycle("jr_fetch",  1'b1, E_FETCH_R);
    runCycle("jr_decode", 1'b1, E_DECODE);
    runCycle("jr_jr",     1'b1, E_JR);

    $display("[TB] unknown opcode");
    setInstr(6'b111111, 6'b000000);
    runCycle("ill_fetch", 1'b1, E_FETCH_R);
`ifdef MC_ILLEGAL_TRAP_EN
    runCycle("ill_decode", 1'b1, E_DECODE);
    runCycle("ill_trap0",  1'b1, E_TRAP);
    runCycle("ill_trap1",  1'b1, E_TRAP);
`else
    runCycle("nop_decode", 1'b1, E_DECODE_NP);
    runCycle("nop_fetch",  1'b0, E_FETCH_W);
`endif
    pulseReset("ill_reset");

    $display("[TB] ready on the timeout limit cycle");
    setInstr(6'b000000, 6'b100000);
    runCycle("lim_idle", 1'b1, E_ZERO);
    for (int i = 0; i < 4; i++) runCycle("lim_wait", 1'b0, E_FETCH_W);
    runCycle("lim_ready",  1'b1, E_FETCH_R);
    runCycle("lim_decode", 1'b1, E_DECODE);
    runCycle("lim_exec",   1'b1, E_EXEC_R);
    runCycle("lim_rwb",    1'b1, E_RWB);

    $display("[TB] reset during MEMWR");
    setInstr(6'b101011, 6'b000000);
    runCycle("swr_fetch",  1'b1, E_FETCH_R);
    runCycle("swr_decode", 1'b1, E_DECODE);
    runCycle("swr_addr",   1'b1, E_MEMADDR);
    applyStimulus(curOp, curFunct, 1'b0);
    #1;
    checkOutput("swr_wr_w0", ctlWord, E_MEMWR_W);
    pulseReset("swr_reset");

    $display("[TB] fetch timeout");
    runCycle("to_idle", 1'b0, E_ZERO);
    for (int i = 0; i < 5; i++) runCycle("to_wait", 1'b0, E_FETCH_W);
    runCycle("to_err0", 1'b0, E_ERR);
    runCycle("to_err1", 1'b1, E_ERR);
    pulseReset("to_reset");
    runCycle("to_idle2",  1'b1, E_ZERO);
    runCycle("to_fetch2", 1'b1, E_FETCH_R);

    $display("[TB] Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
